// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard / stall controller.
//   state_t    : controller state encoding (RUN, MULT)
//   REG_ADDR_W : register specifier width
//   NOP_INSTR  : instruction word loaded into IF/ID on flush or ID/EX on bubble
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        MULT = 1'b1
    } state_t;

    localparam int REG_ADDR_W = 5;

    // addi x0, x0, 0 -- the canonical NOP the datapath substitutes
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that saturates at all-ones and never wraps.
// Ports:
//   clk   in  rising-edge clock
//   rst_n in  asynchronous active-low clear
//   en    in  count enable
//   count out current count value (W bits)
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (en && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
// Sequences the PC, IF/ID and ID/EX registers of a 5-stage pipeline:
// load-use stalls, taken-branch squashes, multi-cycle EX holds, memory-busy
// freezes, and a saturating count of cycles with the PC held.
// Ports:
//   Clk, Reset (async, active-low)
//   rsId, rtId, usesRtId, multStartId : instruction currently in ID
//   idexMemRead, idexRd                : instruction currently in EX
//   branchTakenEx, memBusy             : squash / freeze requests
//   pcWriteEnable, ifidWriteEnable, ifidFlush,
//   idexWriteEnable, idexBubble        : pipeline register controls
//   stallCycles                        : saturating stall-cycle count
// ---------------------------------------------------------------------------
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = pipe_ctrl_pkg::REG_ADDR_W,
    parameter int MULT_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [REG_ADDR_W-1:0] rsId,
    input  logic [REG_ADDR_W-1:0] rtId,
    input  logic                  usesRtId,
    input  logic                  multStartId,
    input  logic                  idexMemRead,
    input  logic [REG_ADDR_W-1:0] idexRd,
    input  logic                  branchTakenEx,
    input  logic                  memBusy,
    output logic                  pcWriteEnable,
    output logic                  ifidWriteEnable,
    output logic                  ifidFlush,
    output logic                  idexWriteEnable,
    output logic                  idexBubble,
    output logic [CNT_W-1:0]      stallCycles
);

    // MULT_CYCLES-1 (the largest value loaded) always fits in this width
    localparam int MCNT_W = (MULT_CYCLES > 2) ? $clog2(MULT_CYCLES) : 1;
    localparam logic [MCNT_W-1:0] MCNT_LOAD = MCNT_W'(MULT_CYCLES - 1);

    state_t            state_reg, state_next;
    logic [MCNT_W-1:0] mult_cnt_reg, mult_cnt_next;
    logic              hazard;
    logic              pc_we, ifid_we, ifid_flush, idex_we, idex_bubble;

    // r0 is hardwired, so a load targeting it can never create a dependency
    assign hazard = idexMemRead && (idexRd != '0) &&
                    ((idexRd == rsId) || (usesRtId && (idexRd == rtId)));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg    <= RUN;
            mult_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            mult_cnt_reg <= mult_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        mult_cnt_next = mult_cnt_reg;
        pc_we         = 1'b0;
        ifid_we       = 1'b0;
        ifid_flush    = 1'b0;
        idex_we       = 1'b0;
        idex_bubble   = 1'b0;

        if (Reset) begin
            unique case (state_reg)
                RUN: begin
                    if (memBusy) begin
                        // full freeze: nothing moves, nothing else is acted on
                    end else if (branchTakenEx) begin
                        // squash wrong-path IF and ID; any hazard or
                        // multi-cycle start in ID belongs to the wrong path
                        pc_we       = 1'b1;
                        ifid_we     = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_we     = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (hazard) begin
                        // hold IF/ID, inject one bubble; the bubble clears
                        // idexMemRead next cycle so the stall lasts one cycle
                        idex_we     = 1'b1;
                        idex_bubble = 1'b1;
                    end else begin
                        pc_we   = 1'b1;
                        ifid_we = 1'b1;
                        idex_we = 1'b1;
                        if (multStartId) begin
                            state_next    = MULT;
                            mult_cnt_next = MCNT_LOAD;
                        end
                    end
                end
                MULT: begin
                    // front end and ID/EX hold while the EX op iterates
                    if (!memBusy) begin
                        mult_cnt_next = mult_cnt_reg - MCNT_W'(1);
                        if (mult_cnt_reg <= MCNT_W'(1)) begin
                            state_next    = RUN;
                            mult_cnt_next = '0;
                        end
                    end
                end
                default: begin
                    state_next    = RUN;
                    mult_cnt_next = '0;
                end
            endcase
        end
    end

    assign pcWriteEnable   = pc_we;
    assign ifidWriteEnable = ifid_we;
    assign ifidFlush       = ifid_flush;
    assign idexWriteEnable = idex_we;
    assign idexBubble      = idex_bubble;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (Clk),
        .rst_n (Reset),
        .en    (!pc_we),
        .count (stallCycles)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// Directed bench for hazard_stall_ctrl with MULT_CYCLES=4 and CNT_W=4.
// Output vector order in every comparison: {pcWE, ifidWE, ifidFlush,
// idexWE, idexBubble}.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    localparam int CNT_W = 4;

    localparam logic [4:0] ADV   = 5'b11010;
    localparam logic [4:0] STALL = 5'b00011;
    localparam logic [4:0] BR    = 5'b11111;
    localparam logic [4:0] HOLD  = 5'b00000;

    logic             clk;
    logic             rst_n;
    logic [4:0]       rs_id, rt_id, idex_rd;
    logic             uses_rt, mult_start, mem_read, br_taken, mem_busy;
    logic             pc_we, ifid_we, ifid_flush, idex_we, idex_bubble;
    logic [CNT_W-1:0] stall_cycles;

    int n_vec;
    int n_err;
    int exp_cnt;

    hazard_stall_ctrl #(
        .REG_ADDR_W  (5),
        .MULT_CYCLES (4),
        .CNT_W       (CNT_W)
    ) dut (
        .Clk             (clk),
        .Reset           (rst_n),
        .rsId            (rs_id),
        .rtId            (rt_id),
        .usesRtId        (uses_rt),
        .multStartId     (mult_start),
        .idexMemRead     (mem_read),
        .idexRd          (idex_rd),
        .branchTakenEx   (br_taken),
        .memBusy         (mem_busy),
        .pcWriteEnable   (pc_we),
        .ifidWriteEnable (ifid_we),
        .ifidFlush       (ifid_flush),
        .idexWriteEnable (idex_we),
        .idexBubble      (idex_bubble),
        .stallCycles     (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, check outputs mid-cycle, clock, then check
    // the stall counter against the running expected count.
    task automatic step(input string tag,
                        input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                        input logic ms, input logic mr, input logic [4:0] rd,
                        input logic br, input logic mb, input logic [4:0] exp_o);
        rs_id      = rs;
        rt_id      = rt;
        uses_rt    = ut;
        mult_start = ms;
        mem_read   = mr;
        idex_rd    = rd;
        br_taken   = br;
        mem_busy   = mb;
        #1;
        check({tag, " outs"}, {11'd0, pc_we, ifid_we, ifid_flush, idex_we, idex_bubble},
              {11'd0, exp_o});
        @(posedge clk);
        #1;
        if (!exp_o[4] && exp_cnt < 15) exp_cnt++;
        check({tag, " cnt"}, {12'd0, stall_cycles}, 16'(exp_cnt));
    endtask

    task automatic idle(input string tag, input logic [4:0] exp_o);
        step(tag, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, exp_o);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_cnt = 0;
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        exp_cnt    = 0;
        rst_n      = 1'b0;
        rs_id      = 5'd5;
        rt_id      = 5'd0;
        uses_rt    = 1'b0;
        mult_start = 1'b1;
        mem_read   = 1'b1;
        idex_rd    = 5'd5;
        br_taken   = 1'b1;
        mem_busy   = 1'b0;

        // reset state: everything forced low despite active requests
        #2;
        check("reset outs", {11'd0, pc_we, ifid_we, ifid_flush, idex_we, idex_bubble}, 16'd0);
        check("reset cnt", {12'd0, stall_cycles}, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // normal advance, load-use via rs, recovery, load-use via rt
        idle("idle", ADV);
        step("lu_rs", 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, STALL);
        idle("after_lu", ADV);
        step("lu_rt", 5'd3, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, STALL);

        // r0 never hazards; rt match ignored when rt unused
        step("r0", 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, ADV);
        step("rt_unused", 5'd3, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, ADV);

        // branch beats hazard and multStart; no MULT entered afterwards
        step("br_hz", 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, BR);
        idle("after_br", ADV);

        // hazard beats multStart, which is re-evaluated next cycle
        step("hz_ms", 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, STALL);
        step("ms_retry", 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, ADV);
        for (int i = 0; i < 3; i++) idle("retry_mult", HOLD);
        idle("retry_done", ADV);

        // memBusy in RUN freezes even with branch and hazard present
        step("busy_run", 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, HOLD);

        // multi-cycle op: 1 advance, 3 holds, back to RUN
        do_reset();
        step("ms", 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, ADV);
        for (int i = 0; i < 3; i++) idle("mult_hold", HOLD);
        idle("mult_done", ADV);
        check("mult total", {12'd0, stall_cycles}, 16'd3);

        // memBusy for 2 cycles mid-MULT extends hold to 5
        do_reset();
        step("ms2", 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, ADV);
        idle("mb_hold1", HOLD);
        step("mb_busy1", 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, HOLD);
        step("mb_busy2", 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, HOLD);
        idle("mb_hold2", HOLD);
        idle("mb_hold3", HOLD);
        idle("mb_done", ADV);
        check("mb total", {12'd0, stall_cycles}, 16'd5);

        // reset asserted on the second MULT cycle
        do_reset();
        step("ms3", 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, ADV);
        idle("rm_hold1", HOLD);
        br_taken   = 1'b1;
        mult_start = 1'b1;
        rst_n      = 1'b0;
        #1;
        check("rm_low outs", {11'd0, pc_we, ifid_we, ifid_flush, idex_we, idex_bubble}, 16'd0);
        check("rm_low cnt", {12'd0, stall_cycles}, 16'd0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_cnt = 0;
        idle("rm_rel1", ADV);
        idle("rm_rel2", ADV);

        // saturation at 15 with a 4-bit counter
        for (int i = 0; i < 20; i++)
            step("sat", 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, HOLD);
        check("sat final", {12'd0, stall_cycles}, 16'd15);
        idle("sat_release", ADV);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
